// File: rtl/sram_test_status.sv
// Status tracker for the SRAM tester: iteration count, first-failure snapshot, LEDs.
// Optional watchdog (STALL state) enabled by defining SRAM_TEST_STATUS_WDOG_EN.
module sram_test_status #(
    parameter int DATA_BITS    = 16,
    parameter int ITER_BITS    = 16,
    parameter int BLINK_CYCLES = 12000000,
    parameter int WDOG_CYCLES  = 1 << 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 test_done,
    input  logic                 test_pass,
    input  logic [2:0]           pattern_state,
    input  logic [DATA_BITS-1:0] read_data,
    input  logic [DATA_BITS-1:0] expected_data,
    output logic [ITER_BITS-1:0] iter_count,
    output logic                 fail_latched,
    output logic [DATA_BITS-1:0] fail_read_data,
    output logic [DATA_BITS-1:0] fail_expected_data,
    output logic [2:0]           fail_pattern_state,
    output logic [ITER_BITS-1:0] fail_iter,
    output logic                 led_pass,
    output logic                 led_fail,
    output logic                 wdog_tripped
);
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FAIL  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    localparam int HB_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(BLINK_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic                 pass_q;
    logic [DATA_BITS-1:0] rd_q, exp_q;
    logic [2:0]           pst_q;
    logic [ITER_BITS-1:0] iter_q, iter_d;
    logic                 fl_q;
    logic [DATA_BITS-1:0] frd_q, fexp_q;
    logic [2:0]           fpst_q;
    logic [ITER_BITS-1:0] fiter_q;
    logic [HB_W-1:0]      hb_q, hb_d;
    logic                 lp_q, lp_d;
    logic                 lf_q;
    logic                 fail_now_s;
    logic                 wdog_exp_s;
    logic                 take_snap_s;

`ifdef SRAM_TEST_STATUS_WDOG_EN
    localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            wt_q;

    // Watchdog counter: restarts on every completed iteration, advances only while running
    always_comb begin
        wd_d = wd_q;
        if (test_done) begin
            wd_d = '0;
        end else if (state_q == ST_RUN && wd_q != WD_LAST) begin
            wd_d = wd_q + WD_W'(1);
        end else begin
            wd_d = wd_q;
        end
    end

    assign wdog_exp_s = (state_q == ST_RUN) && (wd_q == WD_LAST) && !test_done;

    // Watchdog state and sticky trip flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
            wt_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            wt_q <= wt_q | ((state_q == ST_RUN) && (state_d == ST_STALL));
        end
    end

    assign wdog_tripped = wt_q;
`else
    logic [31:0] wdog_cfg_unused_s;
    assign wdog_cfg_unused_s = 32'(WDOG_CYCLES);
    assign wdog_exp_s        = 1'b0;
    assign wdog_tripped      = 1'b0;
`endif

    // Pass flag is sampled alongside the data pipe so the snapshot lines up with the miscompare
    assign fail_now_s  = (state_q == ST_RUN) && !pass_q;
    assign take_snap_s = (state_q == ST_RUN) && (state_d == ST_FAIL);

    // Next state, iteration count and heartbeat
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        hb_d    = hb_q;
        lp_d    = lp_q;
        case (state_q)
            ST_RUN: begin
                if (fail_now_s) begin
                    state_d = ST_FAIL;
                end else if (wdog_exp_s) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAIL:  state_d = ST_FAIL;
            ST_STALL: state_d = ST_STALL;
            default:  state_d = ST_FAIL;
        endcase
        if (state_q == ST_RUN && test_done && test_pass && iter_q != '1) begin
            iter_d = iter_q + ITER_BITS'(1);
        end else begin
            iter_d = iter_q;
        end
        if (state_d == ST_RUN) begin
            if (hb_q == HB_LAST) begin
                hb_d = '0;
                lp_d = ~lp_q;
            end else begin
                hb_d = hb_q + HB_W'(1);
                lp_d = lp_q;
            end
        end else begin
            hb_d = hb_q;
            lp_d = 1'b0;
        end
    end

    // Registered state, input pipe, snapshot and LEDs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pass_q  <= 1'b1;
            rd_q    <= '0;
            exp_q   <= '0;
            pst_q   <= 3'd0;
            iter_q  <= '0;
            fl_q    <= 1'b0;
            frd_q   <= '0;
            fexp_q  <= '0;
            fpst_q  <= 3'd0;
            fiter_q <= '0;
            hb_q    <= '0;
            lp_q    <= 1'b0;
            lf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= test_pass;
            rd_q    <= read_data;
            exp_q   <= expected_data;
            pst_q   <= pattern_state;
            iter_q  <= iter_d;
            hb_q    <= hb_d;
            lp_q    <= lp_d;
            lf_q    <= (state_d != ST_RUN);
            if (take_snap_s) begin
                fl_q    <= 1'b1;
                frd_q   <= rd_q;
                fexp_q  <= exp_q;
                fpst_q  <= pst_q;
                fiter_q <= iter_q;
            end
        end
    end

    assign iter_count         = iter_q;
    assign fail_latched       = fl_q;
    assign fail_read_data     = frd_q;
    assign fail_expected_data = fexp_q;
    assign fail_pattern_state = fpst_q;
    assign fail_iter          = fiter_q;
    assign led_pass           = lp_q;
    assign led_fail           = lf_q;
endmodule

// File: tb/tb_sram_test_status.sv
// Scoreboard bench for sram_test_status: directed stimulus queues expected output
// snapshots stamped with a cycle number; a negedge monitor pops and compares them.
module tb_sram_test_status;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        test_done = 1'b0;
    logic        test_pass = 1'b1;
    logic [2:0]  pattern_state = 3'd0;
    logic [15:0] read_data = 16'h0;
    logic [15:0] expected_data = 16'h0;
    logic [1:0]  iter_count, fail_iter;
    logic        fail_latched, led_pass, led_fail, wdog_tripped;
    logic [15:0] fail_read_data, fail_expected_data;
    logic [2:0]  fail_pattern_state;

    logic        w_reset = 1'b1;
    logic [1:0]  w_iter_count, w_fail_iter;
    logic        w_fail_latched, w_led_pass, w_led_fail, w_wdog_tripped;
    logic [15:0] w_fail_read_data, w_fail_expected_data;
    logic [2:0]  w_fail_pattern_state;

    always #5 clk = ~clk;

    sram_test_status #(.DATA_BITS(16), .ITER_BITS(2), .BLINK_CYCLES(4), .WDOG_CYCLES(1 << 20)) dut (
        .clk(clk), .reset(reset), .test_done(test_done), .test_pass(test_pass),
        .pattern_state(pattern_state), .read_data(read_data), .expected_data(expected_data),
        .iter_count(iter_count), .fail_latched(fail_latched), .fail_read_data(fail_read_data),
        .fail_expected_data(fail_expected_data), .fail_pattern_state(fail_pattern_state),
        .fail_iter(fail_iter), .led_pass(led_pass), .led_fail(led_fail), .wdog_tripped(wdog_tripped)
    );

    // Second instance with a short watchdog; idles in reset unless the watchdog build is tested
    sram_test_status #(.DATA_BITS(16), .ITER_BITS(2), .BLINK_CYCLES(4), .WDOG_CYCLES(8)) dut_w (
        .clk(clk), .reset(w_reset), .test_done(1'b0), .test_pass(1'b1),
        .pattern_state(3'd0), .read_data(16'h0), .expected_data(16'h0),
        .iter_count(w_iter_count), .fail_latched(w_fail_latched), .fail_read_data(w_fail_read_data),
        .fail_expected_data(w_fail_expected_data), .fail_pattern_state(w_fail_pattern_state),
        .fail_iter(w_fail_iter), .led_pass(w_led_pass), .led_fail(w_led_fail), .wdog_tripped(w_wdog_tripped)
    );

    typedef struct {
        string       tag;
        int          at;
        bit          w;
        logic [42:0] v;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          run = 1'b0;
    int          hb_n = 0;
    exp_t        cur;
    logic [42:0] act;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation due at this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur = sb.pop_front();
            if (cur.w)
                act = {w_iter_count, w_fail_latched, w_fail_read_data, w_fail_expected_data,
                       w_fail_pattern_state, w_fail_iter, w_led_pass, w_led_fail, w_wdog_tripped};
            else
                act = {iter_count, fail_latched, fail_read_data, fail_expected_data,
                       fail_pattern_state, fail_iter, led_pass, led_fail, wdog_tripped};
            n_checks++;
            if (act !== cur.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (iter,fl,frd,fexp,fps,fit,lp,lf,wt)",
                         cur.tag, act, cur.v);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!reset && run) hb_n++;
        end
        #1;
    endtask

    function automatic logic hb_led();
        return run ? logic'((hb_n / 4) % 2) : 1'b0;
    endfunction

    task automatic exp_main(input string tag, input logic [1:0] it, input logic fl,
                            input logic [15:0] frd, input logic [15:0] fexp, input logic [2:0] fps,
                            input logic [1:0] fit, input logic lp, input logic lf);
        exp_t e;
        e.tag = tag; e.at = cyc; e.w = 1'b0;
        e.v = {it, fl, frd, fexp, fps, fit, lp, lf, 1'b0};
        sb.push_back(e);
    endtask

    task automatic exp_w(input string tag, input logic lp, input logic lf, input logic wt);
        exp_t e;
        e.tag = tag; e.at = cyc; e.w = 1'b1;
        e.v = {2'd0, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, lp, lf, wt};
        sb.push_back(e);
    endtask

    initial begin
        step(3);
        exp_main("reset", 2'd0, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0; run = 1'b1; hb_n = 0;

        // three passing iterations
        for (int i = 0; i < 3; i++) begin
            test_done = 1'b1; step(1); test_done = 1'b0;
            exp_main("iter_count", 2'(i + 1), 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, hb_led(), 1'b0);
            step(1);
        end
        // two more saturate at all-ones
        for (int i = 0; i < 2; i++) begin
            test_done = 1'b1; step(1); test_done = 1'b0; step(1);
        end
        exp_main("iter_saturate", 2'd3, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, hb_led(), 1'b0);

        // heartbeat toggles every 4 cycles while running
        for (int i = 0; i < 8; i++) begin
            step(1);
            exp_main("heartbeat", 2'd3, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, hb_led(), 1'b0);
        end

        // reset mid-operation clears everything
        reset = 1'b1; step(2);
        exp_main("mid_reset", 2'd0, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0; hb_n = 0;
        test_done = 1'b1; step(1); test_done = 1'b0; step(1);
        exp_main("iter_after_reset", 2'd1, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);

        // miscompare with a simultaneous test_done: no count, FAIL wins
        read_data = 16'hA5A5; expected_data = 16'hA5A4; pattern_state = 3'd2;
        step(1);
        test_pass = 1'b0; test_done = 1'b1;
        step(1);
        test_done = 1'b0;
        read_data = 16'h1234; expected_data = 16'h5678; pattern_state = 3'd5;
        exp_main("pre_fail_toggle", 2'd1, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b1, 1'b0);
        run = 1'b0;
        step(1);
        exp_main("snapshot", 2'd1, 1'b1, 16'hA5A5, 16'hA5A4, 3'd2, 2'd1, 1'b0, 1'b1);

        // further activity after FAIL leaves the snapshot and count untouched
        test_pass = 1'b1; test_done = 1'b1; step(1);
        test_done = 1'b0; test_pass = 1'b0; step(1);
        exp_main("fail_hold_a", 2'd1, 1'b1, 16'hA5A5, 16'hA5A4, 3'd2, 2'd1, 1'b0, 1'b1);
        read_data = 16'hFFFF; test_done = 1'b1; step(1); test_done = 1'b0; step(4);
        exp_main("fail_hold_b", 2'd1, 1'b1, 16'hA5A5, 16'hA5A4, 3'd2, 2'd1, 1'b0, 1'b1);

        // reset while failed, with test_pass still low, returns to RUN
        reset = 1'b1; step(1);
        exp_main("reset_in_fail", 2'd0, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        test_pass = 1'b1; reset = 1'b0; run = 1'b1; hb_n = 0;
        step(1);
        exp_main("run_after_reset", 2'd0, 1'b0, 16'h0, 16'h0, 3'd0, 2'd0, hb_led(), 1'b0);

`ifdef SRAM_TEST_STATUS_WDOG_EN
        // watchdog: no test_done for 8 cycles trips STALL
        w_reset = 1'b1; step(2); w_reset = 1'b0;
        step(7);
        exp_w("wdog_before", 1'b1, 1'b0, 1'b0);
        step(1);
        exp_w("wdog_trip", 1'b0, 1'b1, 1'b1);
        step(3);
        exp_w("wdog_sticky", 1'b0, 1'b1, 1'b1);
        w_reset = 1'b1; step(1);
        exp_w("wdog_reset", 1'b0, 1'b0, 1'b0);
        w_reset = 1'b0; step(1);
        exp_w("wdog_rerun", 1'b0, 1'b0, 1'b0);
`else
        step(2);
        exp_w("wdog_absent", 1'b0, 1'b0, 1'b0);
`endif

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
